mmcm_drp_reconfig: RTL and testbench

- Sequencer that reprograms a running MMCME2_ADV through its DRP port, e.g. to retune CLKOUT0 divide or CLKFBOUT mult without a new bitstream.
- Holds the MMCM in reset, walks a register table doing read-modify-write on each entry, releases reset, then waits for LOCKED.
- Sits beside the MMCM instance in the top level and runs on the same free-running input clock that feeds CLKIN1 and the DCLK pin.

---
 rtl/mmcm_cfg_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 21 ++
 rtl/mmcm_drp_reconfig.sv | 187 ++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_cfg_pkg.sv
// Shared types and constants for the MMCME2 DRP reconfiguration sequencer.
// Holds the DRP geometry, the standard MMCME2 register addresses and the FSM state encoding.
package mmcm_cfg_pkg;

   localparam int unsigned DRP_AW = 7;
   localparam int unsigned DRP_DW = 16;

   localparam logic [DRP_AW-1:0] ADDR_CLKOUT0_REG1 = 7'h08;
   localparam logic [DRP_AW-1:0] ADDR_CLKOUT0_REG2 = 7'h09;
   localparam logic [DRP_AW-1:0] ADDR_CLKFBOUT_REG1 = 7'h14;
   localparam logic [DRP_AW-1:0] ADDR_CLKFBOUT_REG2 = 7'h15;
   localparam logic [DRP_AW-1:0] ADDR_DIVCLK = 7'h16;
   localparam logic [DRP_AW-1:0] ADDR_LOCK_REG1 = 7'h18;
   localparam logic [DRP_AW-1:0] ADDR_LOCK_REG2 = 7'h19;
   localparam logic [DRP_AW-1:0] ADDR_LOCK_REG3 = 7'h1A;
   localparam logic [DRP_AW-1:0] ADDR_FILT_REG1 = 7'h4E;
   localparam logic [DRP_AW-1:0] ADDR_FILT_REG2 = 7'h4F;
   localparam logic [DRP_AW-1:0] ADDR_POWER = 7'h28;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StWrReq,
      StWrWait,
      StRelease,
      StWaitLock,
      StFail
   } state_e;

   // A 1 in mask keeps the bit already in the MMCM register.
   function automatic logic [DRP_DW-1:0] rmw_merge(input logic [DRP_DW-1:0] rdata,
                                                   input logic [DRP_DW-1:0] mask,
                                                   input logic [DRP_DW-1:0] data);
      return (rdata & mask) | (data & ~mask);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// Reprograms a running MMCME2_ADV over DRP: holds it in reset, read-modify-writes every
// table entry, releases reset and waits for LOCKED, flagging a sticky error on any timeout.
module mmcm_drp_reconfig
   import mmcm_cfg_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES  = 23,
   parameter int unsigned IDX_W        = 5,
   parameter int unsigned DRDY_TIMEOUT = 64,
   parameter int unsigned LOCK_TIMEOUT = 65536
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [IDX_W-1:0]  tbl_idx,
   input  logic [DRP_AW-1:0] tbl_addr,
   input  logic [DRP_DW-1:0] tbl_mask,
   input  logic [DRP_DW-1:0] tbl_data,
   output logic              drp_den,
   output logic              drp_dwe,
   output logic [DRP_AW-1:0] drp_daddr,
   output logic [DRP_DW-1:0] drp_di,
   input  logic [DRP_DW-1:0] drp_do,
   input  logic              drp_drdy,
   output logic              mmcm_rst,
   input  logic              mmcm_locked
);

   localparam int unsigned TMR_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] DRDY_LIMIT = TMR_W'(DRDY_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] LOCK_LIMIT = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_e              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d, timer_inc;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DRP_DW-1:0]   rdata_q, rdata_d;
   logic [DRP_AW-1:0]   daddr_q, daddr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                mmcm_rst_q, mmcm_rst_d;
   logic                locked_s;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (mmcm_locked),
      .q   (locked_s)
   );

   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      idx_d      = idx_q;
      rdata_d    = rdata_q;
      daddr_d    = daddr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;
      mmcm_rst_d = mmcm_rst_q;
      drp_den    = 1'b0;
      drp_dwe    = 1'b0;
      drp_di     = '0;
      drp_daddr  = daddr_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               error_d    = 1'b0;
               busy_d     = 1'b1;
               idx_d      = '0;
               mmcm_rst_d = 1'b1;
               state_d    = StRdReq;
            end
         end
         StRdReq: begin
            drp_den   = 1'b1;
            drp_daddr = tbl_addr;
            daddr_d   = tbl_addr;
            timer_d   = '0;
            state_d   = StRdWait;
         end
         StRdWait: begin
            if (drp_drdy) begin
               rdata_d = drp_do;
               state_d = StWrReq;
            end else if (timer_q >= DRDY_LIMIT) begin
               state_d    = StFail;
               error_d    = 1'b1;
               busy_d     = 1'b0;
               mmcm_rst_d = 1'b0;
            end else begin
               timer_d = timer_inc;
            end
         end
         StWrReq: begin
            drp_den   = 1'b1;
            drp_dwe   = 1'b1;
            drp_daddr = tbl_addr;
            daddr_d   = tbl_addr;
            drp_di    = rmw_merge(rdata_q, tbl_mask, tbl_data);
            timer_d   = '0;
            state_d   = StWrWait;
         end
         StWrWait: begin
            if (drp_drdy) begin
               if (idx_q == LAST_IDX) begin
                  mmcm_rst_d = 1'b0;
                  state_d    = StRelease;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StRdReq;
               end
            end else if (timer_q >= DRDY_LIMIT) begin
               state_d    = StFail;
               error_d    = 1'b1;
               busy_d     = 1'b0;
               mmcm_rst_d = 1'b0;
            end else begin
               timer_d = timer_inc;
            end
         end
         StRelease: begin
            mmcm_rst_d = 1'b0;
            timer_d    = '0;
            state_d    = StWaitLock;
         end
         StWaitLock: begin
            if (locked_s) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (timer_q >= LOCK_LIMIT) begin
               state_d    = StFail;
               error_d    = 1'b1;
               busy_d     = 1'b0;
               mmcm_rst_d = 1'b0;
            end else begin
               timer_d = timer_inc;
            end
         end
         StFail: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         idx_q      <= '0;
         rdata_q    <= '0;
         daddr_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         mmcm_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         rdata_q    <= rdata_d;
         daddr_q    <= daddr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         mmcm_rst_q <= mmcm_rst_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign tbl_idx  = idx_q;
   assign mmcm_rst = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig: a two-entry table, a negedge DRP/MMCM model with
// configurable drdy delay and lock behaviour, and hand-computed expected write data.
module tb_mmcm_drp_reconfig;

   localparam int unsigned NUM_ENTRIES  = 2;
   localparam int unsigned IDX_W        = 5;
   localparam int unsigned DRDY_TIMEOUT = 64;
   localparam int unsigned LOCK_TIMEOUT = 300;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy, done, error;
   logic [4:0]  tbl_idx;
   logic [6:0]  tbl_addr;
   logic [15:0] tbl_mask, tbl_data;
   logic        drp_den, drp_dwe;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di, drp_do;
   logic        drp_drdy;
   logic        mmcm_rst, mmcm_locked;

   mmcm_drp_reconfig #(
      .NUM_ENTRIES  (NUM_ENTRIES),
      .IDX_W        (IDX_W),
      .DRDY_TIMEOUT (DRDY_TIMEOUT),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .tbl_idx     (tbl_idx),
      .tbl_addr    (tbl_addr),
      .tbl_mask    (tbl_mask),
      .tbl_data    (tbl_data),
      .drp_den     (drp_den),
      .drp_dwe     (drp_dwe),
      .drp_daddr   (drp_daddr),
      .drp_di      (drp_di),
      .drp_do      (drp_do),
      .drp_drdy    (drp_drdy),
      .mmcm_rst    (mmcm_rst),
      .mmcm_locked (mmcm_locked)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      case (tbl_idx)
         5'd0:    begin tbl_addr = 7'h08; tbl_mask = 16'hF000; tbl_data = 16'h0145; end
         5'd1:    begin tbl_addr = 7'h09; tbl_mask = 16'hFC00; tbl_data = 16'h0080; end
         default: begin tbl_addr = 7'h7F; tbl_mask = 16'hFFFF; tbl_data = 16'h0000; end
      endcase
   end

   int n_vec = 0;
   int n_miss = 0;

   // Model knobs
   int drdy_delay = 0;
   bit no_drdy_first = 1'b0;
   bit lock_en = 1'b1;
   int lock_dly = 100;

   // Model / monitor state
   int cyc = 0;
   bit pending = 1'b0;
   int pend_cnt = 0;
   logic [15:0] pend_data = '0;
   bit drop = 1'b0;
   int lock_cnt = 0;
   int n_rd, n_wr, done_cnt, err_rise, rst_viol, busy_bad, overlap_cnt;
   int first_rd_cyc, rst_fall_cyc, err_cyc, done_cyc;
   logic [6:0]  rd_addr_log[8];
   logic [6:0]  wr_addr_log[8];
   logic [15:0] wr_data_log[8];
   bit busy_prev = 1'b0, rst_prev = 1'b0, err_prev = 1'b0;

   initial begin
      drp_drdy = 1'b0;
      drp_do = '0;
      mmcm_locked = 1'b0;
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      drp_drdy = 1'b0;
      drp_do = 16'h0000;
      if (pending) begin
         if (pend_cnt == 0) begin
            pending = 1'b0;
            drp_drdy = 1'b1;
            drp_do = pend_data;
         end else begin
            pend_cnt = pend_cnt - 1;
         end
      end
      if (drp_den) begin
         if (pending) overlap_cnt++;
         if (!mmcm_rst) rst_viol++;
         if (!drp_dwe) begin
            if (n_rd < 8) rd_addr_log[n_rd] = drp_daddr;
            if (n_rd == 0) first_rd_cyc = cyc;
            drop = no_drdy_first && (n_rd == 0);
            pend_data = (drp_daddr == 7'h08) ? 16'hA5A5 :
                        (drp_daddr == 7'h09) ? 16'h5A5A : 16'h0000;
            n_rd++;
         end else begin
            if (n_wr < 8) begin
               wr_addr_log[n_wr] = drp_daddr;
               wr_data_log[n_wr] = drp_di;
            end
            drop = 1'b0;
            pend_data = 16'h0000;
            n_wr++;
         end
         if (!drop) begin
            pending = 1'b1;
            pend_cnt = drdy_delay;
         end
      end
      if (mmcm_rst) begin
         lock_cnt = 0;
         mmcm_locked = 1'b0;
      end else if (lock_en) begin
         lock_cnt++;
         if (lock_cnt >= lock_dly) mmcm_locked = 1'b1;
      end
      if (busy_prev && !busy && !done && !error) busy_bad++;
      if (rst_prev && !mmcm_rst) rst_fall_cyc = cyc;
      if (error && !err_prev) begin
         err_rise++;
         err_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      busy_prev = busy;
      rst_prev = mmcm_rst;
      err_prev = error;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      n_rd = 0; n_wr = 0; done_cnt = 0; err_rise = 0; rst_viol = 0;
      busy_bad = 0; overlap_cnt = 0; pending = 1'b0;
      first_rd_cyc = 0; rst_fall_cyc = 0; err_cyc = 0; done_cyc = 0;
      for (int i = 0; i < 8; i++) begin
         rd_addr_log[i] = '0;
         wr_addr_log[i] = '0;
         wr_data_log[i] = '0;
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int max_cyc);
      int k = 0;
      while (done_cnt == 0 && err_rise == 0 && k < max_cyc) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq({tag, "_in_budget"}, 32'(k < max_cyc), 32'd1);
      repeat (5) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_good_run(input string tag);
      check_eq({tag, "_n_rd"}, 32'(n_rd), 32'd2);
      check_eq({tag, "_n_wr"}, 32'(n_wr), 32'd2);
      check_eq({tag, "_rd_addr0"}, 32'(rd_addr_log[0]), 32'h08);
      check_eq({tag, "_rd_addr1"}, 32'(rd_addr_log[1]), 32'h09);
      check_eq({tag, "_wr_addr0"}, 32'(wr_addr_log[0]), 32'h08);
      check_eq({tag, "_wr_data0"}, 32'(wr_data_log[0]), 32'hA145);
      check_eq({tag, "_wr_addr1"}, 32'(wr_addr_log[1]), 32'h09);
      check_eq({tag, "_wr_data1"}, 32'(wr_data_log[1]), 32'h5880);
      check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_eq({tag, "_error"}, 32'(error), 32'd0);
      check_eq({tag, "_rst_during_drp"}, 32'(rst_viol), 32'd0);
      check_eq({tag, "_busy_gap"}, 32'(busy_bad), 32'd0);
      check_eq({tag, "_overlap"}, 32'(overlap_cnt), 32'd0);
      check_eq({tag, "_lock_wait"},
               32'((done_cyc - rst_fall_cyc >= 100) && (done_cyc - rst_fall_cyc <= 110)), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      clear_log();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ctrl", 32'({busy, done, error, drp_den, drp_dwe, mmcm_rst}), 32'd0);
      check_eq("rst_idx", 32'(tbl_idx), 32'd0);
      check_eq("rst_daddr", 32'(drp_daddr), 32'd0);
      check_eq("rst_di", 32'(drp_di), 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("idle_ctrl", 32'({busy, done, error, drp_den, mmcm_rst}), 32'd0);

      // Zero-wait DRP, lock 100 cycles after release; 4 cycles per entry
      clear_log();
      pulse_start();
      check_eq("t1_busy_rst", 32'({busy, mmcm_rst}), 32'b11);
      wait_end("t1", 400);
      check_good_run("t1");
      check_eq("t1_drp_cycles", 32'(rst_fall_cyc - first_rd_cyc), 32'd8);

      // drdy ten cycles after every den
      drdy_delay = 9;
      clear_log();
      pulse_start();
      wait_end("t2", 600);
      check_good_run("t2");

      // First read never acknowledged
      drdy_delay = 0;
      no_drdy_first = 1'b1;
      clear_log();
      pulse_start();
      wait_end("t3", 300);
      no_drdy_first = 1'b0;
      check_eq("t3_error", 32'(error), 32'd1);
      check_eq("t3_fail_time", 32'(err_cyc - first_rd_cyc), 32'(DRDY_TIMEOUT + 1));
      check_eq("t3_ctrl", 32'({busy, mmcm_rst, done}), 32'd0);
      check_eq("t3_n_rd", 32'(n_rd), 32'd1);
      check_eq("t3_n_wr", 32'(n_wr), 32'd0);
      check_eq("t3_done_cnt", 32'(done_cnt), 32'd0);

      // LOCKED never rises: fail after LOCK_TIMEOUT wait cycles following RELEASE
      lock_en = 1'b0;
      clear_log();
      pulse_start();
      wait_end("t4", 800);
      check_eq("t4_error", 32'(error), 32'd1);
      check_eq("t4_fail_time", 32'(err_cyc - rst_fall_cyc), 32'(LOCK_TIMEOUT + 1));
      check_eq("t4_done_cnt", 32'(done_cnt), 32'd0);
      check_eq("t4_n_wr", 32'(n_wr), 32'd2);
      lock_en = 1'b1;
      clear_log();
      pulse_start();
      check_eq("t4_error_cleared", 32'(error), 32'd0);
      wait_end("t4b", 400);
      check_good_run("t4b");

      // start hammered while busy
      clear_log();
      pulse_start();
      begin
         int k = 0;
         while (done_cnt == 0 && err_rise == 0 && k < 400) begin
            start = busy && (k % 3 == 0);
            @(posedge clk); #1;
            k++;
         end
         start = 1'b0;
         check_eq("t5_in_budget", 32'(k < 400), 32'd1);
      end
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_good_run("t5");

      // Asynchronous reset in WR_WAIT of entry 1, then a clean restart
      drdy_delay = 9;
      clear_log();
      pulse_start();
      begin
         int k = 0;
         while (n_wr < 2 && k < 200) begin
            @(posedge clk); #1;
            k++;
         end
         check_eq("t6_reach_wr1", 32'(k < 200), 32'd1);
      end
      @(posedge clk); #2;
      check_eq("t6_pre_idx", 32'(tbl_idx), 32'd1);
      check_eq("t6_pre_ctrl", 32'({busy, mmcm_rst}), 32'b11);
      rst = 1'b1;
      #1;
      check_eq("t6_arst_ctrl", 32'({busy, done, error, drp_den, drp_dwe, mmcm_rst}), 32'd0);
      check_eq("t6_arst_idx", 32'(tbl_idx), 32'd0);
      check_eq("t6_arst_daddr", 32'(drp_daddr), 32'd0);
      check_eq("t6_arst_di", 32'(drp_di), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      clear_log();
      pulse_start();
      check_eq("t6_restart_idx", 32'(tbl_idx), 32'd0);
      wait_end("t6", 600);
      check_good_run("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
